// File: rtl/map_port_arbiter.sv
// Two-port arbiter sharing one single-port world-map BRAM between video and bot.
// Define MAP_ARB_STARVE_EN to add the bot starvation counter and forced bot grant.
module map_port_arbiter #(
   parameter int unsigned MAP_AW       = 14,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vid_req,
   input  logic [MAP_AW-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_valid,
   output logic [1:0]        vid_data,
   input  logic              bot_req,
   input  logic [MAP_AW-1:0] bot_addr,
   output logic              bot_gnt,
   output logic              bot_valid,
   output logic [1:0]        bot_data,
   output logic [MAP_AW-1:0] map_addr,
   input  logic [1:0]        map_data
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("map_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   // One-hot style encoding: each grant output is a single state flop bit.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GNT_VID = 2'b01,
      GNT_BOT = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [MAP_AW-1:0] map_addr_q, map_addr_d;
   logic              vid_valid_q, vid_valid_d;
   logic              bot_valid_q, bot_valid_d;
   logic              bot_win;

`ifdef MAP_ARB_STARVE_EN
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] wait_q, wait_d;

   // Bot wins when video is idle or the bot has waited STARVE_LIMIT cycles.
   always_comb begin
      bot_win = bot_req && (!vid_req || (wait_q == LIMIT));
      wait_d  = wait_q;
      if (!bot_req || bot_win) begin
         wait_d = '0;
      end else if (wait_q != LIMIT) begin
         wait_d = wait_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   always_comb begin
      bot_win = bot_req && !vid_req;
   end
`endif

   // Next grant, captured address and read-return strobes.
   always_comb begin
      state_d     = IDLE;
      map_addr_d  = map_addr_q;
      vid_valid_d = (state_q == GNT_VID);
      bot_valid_d = (state_q == GNT_BOT);
      if (bot_win) begin
         state_d    = GNT_BOT;
         map_addr_d = bot_addr;
      end else if (vid_req) begin
         state_d    = GNT_VID;
         map_addr_d = vid_addr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         map_addr_q  <= '0;
         vid_valid_q <= 1'b0;
         bot_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         map_addr_q  <= map_addr_d;
         vid_valid_q <= vid_valid_d;
         bot_valid_q <= bot_valid_d;
      end
   end

   assign vid_gnt   = (state_q == GNT_VID);
   assign bot_gnt   = (state_q == GNT_BOT);
   assign vid_valid = vid_valid_q;
   assign bot_valid = bot_valid_q;
   assign map_addr  = map_addr_q;
   // BRAM output is shared; the valid strobes identify the owner.
   assign vid_data  = map_data;
   assign bot_data  = map_data;

endmodule

// File: doc/map_port_arbiter.md
MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

Interface
REQ-001 Parameter: MAP_AW, 14, world-map address width ({row[6:0], col[6:0]}, 128x128 map).
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive denied bot cycles before forced bot grant (legal 1..15).
REQ-003 Port: clk  in  1  system clock; all state changes on rising edge.
REQ-004 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: vid_req  in  1  video pixel-fetch request.
REQ-006 Port: vid_addr  in  MAP_AW  video map address, stable while vid_req is high and ungranted.
REQ-007 Port: vid_gnt  out  1  one-cycle video grant pulse.
REQ-008 Port: vid_valid  out  1  video read data valid.
REQ-009 Port: vid_data  out  2  video map pixel.
REQ-010 Port: bot_req  in  1  bot/CPU map-lookup request.
REQ-011 Port: bot_addr  in  MAP_AW  bot map address, stable while bot_req is high and ungranted.
REQ-012 Port: bot_gnt  out  1  one-cycle bot grant pulse.
REQ-013 Port: bot_valid  out  1  bot read data valid.
REQ-014 Port: bot_data  out  2  bot map pixel.
REQ-015 Port: map_addr  out  MAP_AW  registered address to the single-port map BRAM.
REQ-016 Port: map_data  in  2  BRAM read data, valid one cycle after map_addr.

Function
REQ-017 The arbiter SHALL use a three-state FSM (IDLE, GNT_VID, GNT_BOT) whose state names the requester granted in the current cycle.
REQ-018 At each edge the arbiter SHALL sample the requests and enter GNT_VID, GNT_BOT or IDLE (no request) for the next cycle.
REQ-019 In GNT_VID / GNT_BOT, the matching gnt SHALL be high for exactly that cycle and map_addr SHALL hold the granted address, registered at that entering edge.
REQ-020 Request at edge N, granted: gnt and map_addr in cycle N+1; valid high in cycle N+2 with data = map_data.
REQ-021 vid_data and bot_data SHALL both carry map_data; only the valid strobes distinguish owner.
REQ-022 Grants SHALL be issuable every cycle (back-to-back, either requester), so up to two reads are in flight.
REQ-023 A requester holding req high after its gnt SHALL be treated as making a new request.
REQ-024 Simultaneous requests: video wins unless the starvation rule (REQ-026) applies.
REQ-025 vid_gnt and bot_gnt SHALL never be high in the same cycle; likewise vid_valid and bot_valid.
REQ-026 When compiled in (REQ-031), a 4-bit wait counter SHALL count cycles with bot_req high and bot not granted, saturate at STARVE_LIMIT, clear on bot grant or bot_req low; at STARVE_LIMIT the next grant SHALL go to bot even if vid_req is high.
REQ-027 map_addr SHALL hold its last value in IDLE.

Reset
REQ-028 While reset_n is low: state IDLE; vid_gnt, bot_gnt, vid_valid, bot_valid = 0; map_addr = 0; wait counter = 0.
REQ-029 Reset asserted mid-operation SHALL drop in-flight reads immediately (no valid produced for them after reset release).
REQ-030 First grant after release SHALL occur no earlier than the cycle following the first edge with reset_n high.

Configuration
REQ-031 Macro MAP_ARB_STARVE_EN: defined -> starvation counter and forced bot grant (REQ-026) present; undefined -> strict video priority, counter absent, bot granted only in cycles with vid_req low.

Verification
REQ-032 Single bot_req, bot_addr=0x0123, map holds 2'b10 there -> bot_gnt cycle N+1, map_addr=0x0123, bot_valid with bot_data=2'b10 cycle N+2.
REQ-033 vid_req and bot_req both high continuously, STARVE_LIMIT=4, macro defined -> grant pattern V,V,V,V,B repeating; gnts never overlap.
REQ-034 Same as REQ-033 with macro undefined -> only vid_gnt pulses; bot_gnt stays 0 until vid_req drops, then bot_gnt next cycle.
REQ-035 Alternating grants V(0x0010), B(0x0020), V(0x0030) back-to-back -> valids in order V,B,V, each carrying the map value of its address.
REQ-036 reset_n low for one cycle while a grant is in flight -> all outputs 0 immediately, no valid for that read after release, counter restarts at 0.
